// File: rtl/perf_monitor.sv
// Cycle/event performance monitor that stops counting once the CPU parks at FINAL_PC.
// Define PERF_SATURATE_EN to make counters stick at all-ones instead of wrapping.
module perf_monitor #(
  parameter int                  PC_WIDTH    = 16,
  parameter int                  CNT_WIDTH   = 32,
  parameter int                  NUM_EVENTS  = 4,
  parameter logic [PC_WIDTH-1:0] FINAL_PC    = 'h00FF,
  parameter int                  HOLD_CYCLES = 2,
  parameter int                  AUTO_START  = 1
) (
  input  logic                  clk,
  input  logic                  resetN,
  input  logic [PC_WIDTH-1:0]   pc,
  input  logic [NUM_EVENTS-1:0] events,
  input  logic                  start,
  input  logic [3:0]            sel,
  output logic [CNT_WIDTH-1:0]  count_out,
  output logic                  running,
  output logic                  finished,
  output logic [NUM_EVENTS:0]   overflow,
  output logic [1:0]            state_dbg
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  // Wide enough to hold HOLD_CYCLES, the value reached on the completing edge.
  localparam int MW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES + 1) : 1;

  state_t               state;
  state_t               state_next;
  logic                 clear_all;
  logic                 in_run;
  logic                 pc_hit;
  logic                 last_hit;
  logic [MW-1:0]        match_cnt;
  logic [NUM_EVENTS:0]  inc;
  logic [CNT_WIDTH-1:0] cnt [0:NUM_EVENTS];
  logic [CNT_WIDTH-1:0] sel_val;

  assign in_run    = (state == S_RUN);
  assign pc_hit    = (pc == FINAL_PC);
  assign last_hit  = pc_hit && (match_cnt == MW'(HOLD_CYCLES - 1));
  assign inc       = {events, 1'b1} & {(NUM_EVENTS + 1){in_run}};
  assign state_dbg = state;

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      state <= S_IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    clear_all  = 1'b0;
    case (state)
      S_IDLE: begin
        if (start || (AUTO_START != 0)) begin
          state_next = S_RUN;
          clear_all  = 1'b1;
        end
      end
      S_RUN: begin
        if (last_hit) begin
          state_next = S_DONE;
        end
      end
      S_DONE: begin
        if (start) begin
          state_next = S_RUN;
          clear_all  = 1'b1;
        end
      end
      default: state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      match_cnt <= '0;
    end else if (clear_all) begin
      match_cnt <= '0;
    end else if (in_run) begin
      match_cnt <= pc_hit ? match_cnt + MW'(1) : '0;
    end
  end

  // Index 0 is the cycle counter; index i+1 counts events[i].
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      for (int i = 0; i <= NUM_EVENTS; i++) begin
        cnt[i] <= '0;
      end
      overflow <= '0;
    end else if (clear_all) begin
      for (int i = 0; i <= NUM_EVENTS; i++) begin
        cnt[i] <= '0;
      end
      overflow <= '0;
    end else begin
      for (int i = 0; i <= NUM_EVENTS; i++) begin
        if (inc[i]) begin
          if (&cnt[i]) begin
            overflow[i] <= 1'b1;
`ifdef PERF_SATURATE_EN
            cnt[i] <= cnt[i];
`else
            cnt[i] <= '0;
`endif
          end else begin
            cnt[i] <= cnt[i] + CNT_WIDTH'(1);
          end
        end
      end
    end
  end

  always_comb begin
    sel_val = '0;
    for (int i = 0; i <= NUM_EVENTS; i++) begin
      if (sel == 4'(i)) begin
        sel_val = cnt[i];
      end
    end
  end

  // Flags come from the next state so they line up with the state register.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      count_out <= '0;
      running   <= 1'b0;
      finished  <= 1'b0;
    end else begin
      count_out <= sel_val;
      running   <= (state_next == S_RUN);
      finished  <= (state_next == S_DONE);
    end
  end

endmodule

// File: tb/tb_perf_monitor.sv
// Bench for perf_monitor: directed scenarios on three configurations plus a
// randomized run of the default configuration against a behavioural model.
module tb_perf_monitor;

  localparam logic [15:0] FINAL = 16'h00FF;
  localparam int HOLD = 2;
  localparam int P_IDLE = 0;
  localparam int P_RUN = 1;
  localparam int P_DONE = 2;

  int errors = 0;
  int checks = 0;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // default configuration
  logic        a_resetN, a_start;
  logic [15:0] a_pc;
  logic [3:0]  a_events, a_sel;
  logic [31:0] a_count;
  logic        a_running, a_finished;
  logic [4:0]  a_ovf;
  logic [1:0]  a_state;

  // 4-bit counters
  logic        w_resetN, w_start;
  logic [15:0] w_pc;
  logic [3:0]  w_events, w_sel;
  logic [3:0]  w_count;
  logic        w_running, w_finished;
  logic [4:0]  w_ovf;
  logic [1:0]  w_state;

  // AUTO_START=0
  logic        n_resetN, n_start;
  logic [15:0] n_pc;
  logic [3:0]  n_events, n_sel;
  logic [31:0] n_count;
  logic        n_running, n_finished;
  logic [4:0]  n_ovf;
  logic [1:0]  n_state;

  perf_monitor u_a (
    .clk(clk), .resetN(a_resetN), .pc(a_pc), .events(a_events), .start(a_start),
    .sel(a_sel), .count_out(a_count), .running(a_running), .finished(a_finished),
    .overflow(a_ovf), .state_dbg(a_state)
  );

  perf_monitor #(.CNT_WIDTH(4)) u_w (
    .clk(clk), .resetN(w_resetN), .pc(w_pc), .events(w_events), .start(w_start),
    .sel(w_sel), .count_out(w_count), .running(w_running), .finished(w_finished),
    .overflow(w_ovf), .state_dbg(w_state)
  );

  perf_monitor #(.AUTO_START(0)) u_i (
    .clk(clk), .resetN(n_resetN), .pc(n_pc), .events(n_events), .start(n_start),
    .sel(n_sel), .count_out(n_count), .running(n_running), .finished(n_finished),
    .overflow(n_ovf), .state_dbg(n_state)
  );

  // Behavioural model of u_a: a run counts every edge and every event, and ends
  // once FINAL has been seen on HOLD consecutive run edges.
  int          m_phase;
  int          m_streak;
  logic [31:0] m_cyc;
  logic [31:0] m_ev [4];
  logic [31:0] m_out;
  logic [4:0]  m_ovf;

  function automatic logic [31:0] pick(input logic [3:0] s);
    if (s == 4'd0) return m_cyc;
    if (s <= 4'd4) return m_ev[int'(s) - 1];
    return 32'd0;
  endfunction

  always @(posedge clk or negedge a_resetN) begin
    if (!a_resetN) begin
      m_phase <= P_IDLE;
      m_streak <= 0;
      m_cyc <= '0;
      m_out <= '0;
      m_ovf <= '0;
      for (int i = 0; i < 4; i++) m_ev[i] <= '0;
    end else begin
      m_out <= pick(a_sel);
      if (m_phase == P_IDLE || (m_phase == P_DONE && a_start)) begin
        m_phase <= P_RUN;
        m_streak <= 0;
        m_cyc <= '0;
        m_ovf <= '0;
        for (int i = 0; i < 4; i++) m_ev[i] <= '0;
      end else if (m_phase == P_RUN) begin
        m_cyc <= m_cyc + 32'd1;
        if (m_cyc == 32'hFFFF_FFFF) m_ovf[0] <= 1'b1;
        for (int i = 0; i < 4; i++) begin
          if (a_events[i]) begin
            m_ev[i] <= m_ev[i] + 32'd1;
            if (m_ev[i] == 32'hFFFF_FFFF) m_ovf[i+1] <= 1'b1;
          end
        end
        if (a_pc == FINAL) begin
          m_streak <= m_streak + 1;
          if (m_streak + 1 >= HOLD) m_phase <= P_DONE;
        end else begin
          m_streak <= 0;
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    a_resetN = 1'b0; w_resetN = 1'b0; n_resetN = 1'b0;
    a_start = 1'b0; a_pc = 16'd0; a_events = 4'd0; a_sel = 4'd0;
    w_start = 1'b0; w_pc = 16'd0; w_events = 4'd0; w_sel = 4'd0;
    n_start = 1'b0; n_pc = 16'd0; n_events = 4'd0; n_sel = 4'd0;
    repeat (2) tick();
    checks++;
    if ({a_count, a_running, a_finished, a_ovf} !== 39'd0) begin
      errors++; $display("FAIL reset_a: got %h expected 0", {a_count, a_running, a_finished, a_ovf});
    end
    checks++;
    if ({w_count, w_running, w_finished, w_ovf} !== 11'd0) begin
      errors++; $display("FAIL reset_w: got %h expected 0", {w_count, w_running, w_finished, w_ovf});
    end
    checks++;
    if ({n_count, n_running, n_finished, n_ovf} !== 39'd0) begin
      errors++; $display("FAIL reset_n: got %h expected 0", {n_count, n_running, n_finished, n_ovf});
    end
  endtask

  task automatic test_completion();
    a_resetN = 1'b1;
    tick();
    checks++;
    if (a_running !== 1'b1) begin
      errors++; $display("FAIL autostart_running: got %b expected 1", a_running);
    end
    repeat (100) tick();
    a_pc = FINAL;
    tick();
    checks++;
    if ({a_running, a_finished} !== 2'b10) begin
      errors++; $display("FAIL first_match_flags: got %b expected 10", {a_running, a_finished});
    end
    tick();
    checks++;
    if ({a_running, a_finished} !== 2'b01) begin
      errors++; $display("FAIL completion_flags: got %b expected 01", {a_running, a_finished});
    end
    tick();
    checks++;
    if (a_count !== 32'd102) begin
      errors++; $display("FAIL completion_cycles: got %0d expected 102", a_count);
    end
  endtask

  task automatic test_glitch();
    a_pc = 16'd0;
    a_start = 1'b1;
    tick();
    a_start = 1'b0;
    a_pc = FINAL;
    tick();
    a_pc = 16'h0100;
    tick();
    a_pc = FINAL;
    tick();
    checks++;
    if ({a_running, a_finished} !== 2'b10) begin
      errors++; $display("FAIL glitch_not_done: got %b expected 10", {a_running, a_finished});
    end
    tick();
    checks++;
    if ({a_running, a_finished} !== 2'b01) begin
      errors++; $display("FAIL glitch_done: got %b expected 01", {a_running, a_finished});
    end
    tick();
    checks++;
    if (a_count !== 32'd4) begin
      errors++; $display("FAIL glitch_cycles: got %0d expected 4", a_count);
    end
  endtask

  task automatic test_events();
    a_pc = 16'd0;
    a_start = 1'b1;
    tick();
    a_start = 1'b0;
    a_events = 4'b0100;
    repeat (5) tick();
    a_pc = FINAL;
    repeat (2) tick();
    checks++;
    if (a_finished !== 1'b1) begin
      errors++; $display("FAIL events_done: got %b expected 1", a_finished);
    end
    a_sel = 4'd3;
    repeat (3) tick();
    checks++;
    if (a_count !== 32'd7) begin
      errors++; $display("FAIL events_held: got %0d expected 7", a_count);
    end
    a_events = 4'd0;
    a_pc = 16'd0;
    a_start = 1'b1;
    tick();
    a_start = 1'b0;
    checks++;
    if (a_running !== 1'b1) begin
      errors++; $display("FAIL restart_running: got %b expected 1", a_running);
    end
    tick();
    checks++;
    if (a_count !== 32'd0) begin
      errors++; $display("FAIL restart_cleared: got %0d expected 0", a_count);
    end
  endtask

  task automatic test_async_reset();
    a_sel = 4'd0;
    repeat (5) tick();
    checks++;
    if (a_count !== m_out || a_count == 32'd0) begin
      errors++; $display("FAIL prereset_count: got %0d expected %0d (nonzero)", a_count, m_out);
    end
    #2 a_resetN = 1'b0;
    #1;
    checks++;
    if ({a_count, a_running, a_finished, a_ovf} !== 39'd0) begin
      errors++; $display("FAIL async_reset: got %h expected 0", {a_count, a_running, a_finished, a_ovf});
    end
    tick();
    a_resetN = 1'b1;
    tick();
  endtask

  task automatic test_wrap();
    w_resetN = 1'b1;
    tick();
    repeat (15) tick();
    checks++;
    if (w_ovf !== 5'b00000) begin
      errors++; $display("FAIL wrap_no_ovf_yet: got %b expected 00000", w_ovf);
    end
    repeat (5) tick();
    checks++;
    if (w_ovf !== 5'b00001) begin
      errors++; $display("FAIL wrap_ovf: got %b expected 00001", w_ovf);
    end
    tick();
    checks++;
`ifdef PERF_SATURATE_EN
    if (w_count !== 4'd15) begin
      errors++; $display("FAIL wrap_count: got %0d expected 15", w_count);
    end
`else
    if (w_count !== 4'd4) begin
      errors++; $display("FAIL wrap_count: got %0d expected 4", w_count);
    end
`endif
  endtask

  task automatic test_no_autostart();
    n_resetN = 1'b1;
    n_events = 4'hF;
    for (int k = 0; k < 50; k++) begin
      n_pc = (k % 5 == 0) ? FINAL : 16'(k);
      tick();
    end
    checks++;
    if ({n_count, n_running, n_finished, n_ovf} !== 39'd0) begin
      errors++; $display("FAIL idle_hold: got %h expected 0", {n_count, n_running, n_finished, n_ovf});
    end
    n_pc = 16'd0;
    n_start = 1'b1;
    tick();
    n_start = 1'b0;
    repeat (5) tick();
    n_events = 4'd0;
    n_sel = 4'd9;
    tick();
    checks++;
    if (n_count !== 32'd0) begin
      errors++; $display("FAIL sel_out_of_range: got %0d expected 0", n_count);
    end
    n_sel = 4'd1;
    tick();
    checks++;
    if (n_count !== 32'd5) begin
      errors++; $display("FAIL sel_event0: got %0d expected 5", n_count);
    end
    n_sel = 4'd0;
    tick();
    checks++;
    if (n_count !== 32'd7 || n_running !== 1'b1) begin
      errors++; $display("FAIL started_cycles: got %0d/%b expected 7/1", n_count, n_running);
    end
  endtask

  task automatic test_random();
    for (int k = 0; k < 400; k++) begin
      a_pc = ($urandom_range(0, 2) == 0) ? FINAL : 16'($urandom);
      a_events = 4'($urandom);
      a_start = ($urandom_range(0, 9) == 0);
      a_sel = 4'($urandom_range(0, 15));
      tick();
      checks++;
      if (a_count !== m_out) begin
        errors++; $display("FAIL random_count[%0d]: got %0d expected %0d", k, a_count, m_out);
      end
      checks++;
      if ({a_running, a_finished, a_ovf} !== {m_phase == P_RUN, m_phase == P_DONE, m_ovf}) begin
        errors++; $display("FAIL random_flags[%0d]: got %b expected %b", k,
          {a_running, a_finished, a_ovf}, {m_phase == P_RUN, m_phase == P_DONE, m_ovf});
      end
    end
    a_start = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    test_reset();
    test_completion();
    test_glitch();
    test_events();
    test_async_reset();
    test_wrap();
    test_no_autostart();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
